unidad_logico_aritmetica_secuencial: RTL

Registered, handshaked, width-parametrised ALU that succeeds the combinational `unidad_logico_aritmetica`. It keeps the same 4-bit operation encoding and the N/Z/V/C flag set. It adds a variable shift amount, an iterative unsigned multiply, a compare operation, and valid/ready flow control on both sides. It sits between the operand-fetch stage and the writeback/flags register of the datapath.

---
 rtl/unidad_logico_aritmetica_secuencial.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/unidad_logico_aritmetica_secuencial.sv
// Registered, handshaked ALU with valid/ready on both sides.
// Single-cycle opcodes complete on accept; MUL runs N shift-add steps before completing.
module unidad_logico_aritmetica_secuencial #(
   parameter int unsigned N  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_in,
   output logic          ready_out,
   input  logic [N-1:0]  numero1,
   input  logic [N-1:0]  numero2,
   input  logic [3:0]    ALUControl,
   input  logic [SW-1:0] desplazamiento,
   output logic          valid_out,
   input  logic          ready_in,
   output logic [N-1:0]  resultado,
   output logic          flagNegativo,
   output logic          flagCero,
   output logic          flagOverflow,
   output logic          flagCarry
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [3:0] OpMul = 4'b1110;
   localparam logic [3:0] OpCmp = 4'b1111;
   localparam logic [CW-1:0] LastStep = CW'(N - 1);

   typedef enum logic {
      IDLE,
      MUL
   } estado_t;

   estado_t estado;
   logic [CW-1:0] contador;
   logic [2*N-1:0] multiplicando;
   logic [2*N-1:0] acumulador;
   logic [N-1:0] multiplicador;

   logic acepta;
   logic [N:0] suma;
   logic [N:0] resta;
   logic signed [N-1:0] aSigned;
   logic signed [N-1:0] bSigned;
   logic [2*N-1:0] acumSig;

   logic [N-1:0] resComb;
   logic [N-1:0] valorFlags;
   logic overflowComb;
   logic carryComb;

   assign ready_out = (estado == IDLE) && (!valid_out || ready_in);
   assign acepta    = valid_in && ready_out;

   // Extra top bit holds carry-out for ADD and borrow for SUB/CMP.
   assign suma    = {1'b0, numero1} + {1'b0, numero2};
   assign resta   = {1'b0, numero1} - {1'b0, numero2};
   assign aSigned = numero1;
   assign bSigned = numero2;

   assign acumSig = multiplicador[0] ? (acumulador + multiplicando) : acumulador;

   always_comb begin
      resComb      = '0;
      overflowComb = 1'b0;
      carryComb    = 1'b0;
      case (ALUControl)
         4'b0000: resComb = numero1 & numero2;
         4'b0001: resComb = numero1 | numero2;
         4'b0010: resComb = numero1 ^ numero2;
         4'b0011: resComb = ~numero1;
         4'b0100: resComb = numero1 >> desplazamiento;
         4'b0101: resComb = numero1 << desplazamiento;
         4'b0110: resComb = numero2 >> desplazamiento;
         4'b0111: resComb = numero2 << desplazamiento;
         4'b1000: begin
            resComb      = suma[N-1:0];
            carryComb    = suma[N];
            overflowComb = (numero1[N-1] == numero2[N-1]) && (suma[N-1] != numero1[N-1]);
         end
         4'b1001: begin
            resComb      = resta[N-1:0];
            carryComb    = !resta[N];
            overflowComb = (numero1[N-1] != numero2[N-1]) && (resta[N-1] != numero1[N-1]);
         end
         4'b1010: resComb = aSigned >>> desplazamiento;
         4'b1011: resComb = numero1 << desplazamiento;
         4'b1100: resComb = bSigned >>> desplazamiento;
         4'b1101: resComb = numero2 << desplazamiento;
         4'b1111: begin
            resComb      = numero1;
            carryComb    = !resta[N];
            overflowComb = (numero1[N-1] != numero2[N-1]) && (resta[N-1] != numero1[N-1]);
         end
         default: resComb = '0;
      endcase
      // CMP reports A but flags the difference.
      valorFlags = (ALUControl == OpCmp) ? resta[N-1:0] : resComb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado        <= IDLE;
         contador      <= '0;
         multiplicando <= '0;
         multiplicador <= '0;
         acumulador    <= '0;
         valid_out     <= 1'b0;
         resultado     <= '0;
         flagNegativo  <= 1'b0;
         flagCero      <= 1'b0;
         flagOverflow  <= 1'b0;
         flagCarry     <= 1'b0;
      end else begin
         unique case (estado)
            IDLE: begin
               if (acepta) begin
                  if (ALUControl == OpMul) begin
                     multiplicando <= {{N{1'b0}}, numero1};
                     multiplicador <= numero2;
                     acumulador    <= '0;
                     contador      <= '0;
                     valid_out     <= 1'b0;
                     estado        <= MUL;
                  end else begin
                     resultado    <= resComb;
                     flagNegativo <= valorFlags[N-1];
                     flagCero     <= (valorFlags == '0);
                     flagOverflow <= overflowComb;
                     flagCarry    <= carryComb;
                     valid_out    <= 1'b1;
                  end
               end else if (ready_in) begin
                  valid_out <= 1'b0;
               end
            end
            MUL: begin
               acumulador    <= acumSig;
               multiplicando <= multiplicando << 1;
               multiplicador <= multiplicador >> 1;
               contador      <= contador + 1'b1;
               if (ready_in) begin
                  valid_out <= 1'b0;
               end
               if (contador == LastStep) begin
                  resultado    <= acumSig[N-1:0];
                  flagNegativo <= acumSig[N-1];
                  flagCero     <= (acumSig[N-1:0] == '0);
                  flagOverflow <= (acumSig[2*N-1:N] != '0);
                  flagCarry    <= (acumSig[2*N-1:N] != '0);
                  valid_out    <= 1'b1;
                  contador     <= '0;
                  estado       <= IDLE;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule
